uart_fifo_ext: RTL

- Parametrised next-generation byte/word FIFO for the UART datapath, between the RX deserialiser and the case-conversion logic, and between that logic and the TX serialiser.
- Extends the basic synchronous FIFO with:
  - correct simultaneous read/write accounting, including at full;
  - arbitrary (non-power-of-two) depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - programmable almost-full/almost-empty flags and a fill-level output;
  - synchronous flush and sticky overflow/underflow error flags.

---
 rtl/uart_fifo_ext.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_fifo_ext.sv
// Synchronous FIFO for the UART datapath: any depth, standard or first-word-fall-through
// read, programmable almost flags, fill level, flush and sticky overflow/underflow flags.
module uart_fifo_ext #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_clr_err,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             overflow_reg, underflow_reg;
  logic             rd_acc, wr_acc, wr_drop, rd_drop;

  // Pointers wrap explicitly so non-power-of-two depths stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flush swallows both requests without flagging them as errors.
  always_comb begin
    rd_acc  = !i_flush && i_rd_en && (level_reg != '0);
    wr_acc  = !i_flush && i_wr_en && ((level_reg != LW'(DEPTH)) || rd_acc);
    wr_drop = !i_flush && i_wr_en && !wr_acc;
    rd_drop = !i_flush && i_rd_en && !rd_acc;
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= i_wr_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_acc) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr_acc, rd_acc})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_drop)        overflow_reg  <= 1'b1;
      else if (i_clr_err) overflow_reg  <= 1'b0;
      if (rd_drop)        underflow_reg <= 1'b1;
      else if (i_clr_err) underflow_reg <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_rd_data  = mem[rd_ptr_reg];
      assign o_rd_valid = (level_reg != '0);
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_reg;
      logic             rd_valid_reg;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_acc;
          if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
        end
      end
      assign o_rd_data  = rd_data_reg;
      assign o_rd_valid = rd_valid_reg;
    end
  endgenerate

  assign o_level        = level_reg;
  assign o_empty        = (level_reg == '0);
  assign o_full         = (level_reg == LW'(DEPTH));
  assign o_almost_full  = (level_reg >= LW'(AF_THRESH));
  assign o_almost_empty = (level_reg <= LW'(AE_THRESH));
  assign o_overflow     = overflow_reg;
  assign o_underflow    = underflow_reg;

endmodule
